// File: rtl/ucsbece154b_victim_miss_ctrl.sv
// ucsbece154b_victim_miss_ctrl
//   Miss/swap controller between a clean instruction-side L1 and a fully
//   associative victim cache. On an L1 miss it probes the victim cache and
//   writes the L1's evicted line into it. A victim hit returns the line to L1
//   as a swap. A victim miss fetches the line from memory. Saturating hit and
//   miss counters are kept.
//
// Ports
//   clk_i, rst_ni             clock, async active-low reset
//   flush_i, en_i             flush / enable (en_i low acts as flush)
//   miss_*                    L1 miss request (valid/ready handshake)
//   evict_*                   line evicted by L1 alongside the miss
//   fill_*                    one-cycle fill pulse back to L1
//   vc_raddr_o/rdata_i/hit_i  victim cache probe (combinational hit)
//   vc_we_o/waddr_o/wdata_o   victim cache write of the evicted line
//   mem_req_*                 line request to memory (valid/ready)
//   mem_rsp_*                 single-beat memory response, no backpressure
//   vc_hit_cnt_o/miss_cnt_o   saturating performance counters
module ucsbece154b_victim_miss_ctrl #(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  en_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  input  logic                  evict_valid_i,
  input  logic [ADDR_WIDTH-1:0] evict_addr_i,
  input  logic [LINE_WIDTH-1:0] evict_data_i,
  output logic                  fill_valid_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [LINE_WIDTH-1:0] fill_data_o,
  output logic                  fill_from_vc_o,
  output logic [ADDR_WIDTH-1:0] vc_raddr_o,
  input  logic [LINE_WIDTH-1:0] vc_rdata_i,
  input  logic                  vc_hit_i,
  output logic                  vc_we_o,
  output logic [ADDR_WIDTH-1:0] vc_waddr_o,
  output logic [LINE_WIDTH-1:0] vc_wdata_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data_i,
  output logic [CNT_WIDTH-1:0]  vc_hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  vc_miss_cnt_o
);

  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH/8);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_FILL
  } state_t;

  state_t                state_q, state_d;
  logic                  abort_q, abort_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q;
  logic                  evict_valid_q;
  logic [ADDR_WIDTH-1:0] evict_addr_q;
  logic [LINE_WIDTH-1:0] evict_data_q;
  logic [LINE_WIDTH-1:0] fill_data_q;
  logic                  fill_from_vc_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;

  logic kill, capture, latch_vc, latch_mem, hit_inc, miss_inc;
  logic [ADDR_WIDTH-1:0] line_addr;

  // disable behaves exactly like flush
  assign kill      = flush_i | ~en_i;
  assign line_addr = {miss_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

  assign vc_raddr_o     = miss_addr_q;
  assign vc_waddr_o     = evict_addr_q;
  assign vc_wdata_o     = evict_data_q;
  assign fill_addr_o    = line_addr;
  assign fill_data_o    = fill_data_q;
  assign fill_from_vc_o = fill_from_vc_q;
  assign mem_req_addr_o = line_addr;
  assign vc_hit_cnt_o   = hit_cnt_q;
  assign vc_miss_cnt_o  = miss_cnt_q;

  always_comb begin
    state_d         = state_q;
    abort_d         = abort_q;
    miss_ready_o    = 1'b0;
    vc_we_o         = 1'b0;
    mem_req_valid_o = 1'b0;
    fill_valid_o    = 1'b0;
    capture         = 1'b0;
    latch_vc        = 1'b0;
    latch_mem       = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abort_d      = 1'b0;
        miss_ready_o = ~kill;
        if (miss_valid_i && !kill) begin
          capture = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          // evicted line goes into the victim cache whether or not we hit;
          // a duplicate tag after a swap is harmless since L1 lines are clean
          vc_we_o = evict_valid_q;
          if (vc_hit_i) begin
            latch_vc = 1'b1;
            hit_inc  = 1'b1;
            state_d  = S_FILL;
          end else begin
            miss_inc = 1'b1;
            state_d  = S_MEM_REQ;
          end
        end
      end
      S_MEM_REQ: begin
        // request cannot be withdrawn once raised; flush only marks it dead
        mem_req_valid_o = 1'b1;
        if (kill) abort_d = 1'b1;
        if (mem_req_ready_i) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (kill) abort_d = 1'b1;
        if (mem_rsp_valid_i) begin
          if (abort_q || kill) begin
            state_d = S_IDLE;
          end else begin
            latch_mem = 1'b1;
            state_d   = S_FILL;
          end
        end
      end
      S_FILL: begin
        fill_valid_o = ~kill;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_addr_q    <= '0;
      evict_valid_q  <= 1'b0;
      evict_addr_q   <= '0;
      evict_data_q   <= '0;
      fill_data_q    <= '0;
      fill_from_vc_q <= 1'b0;
    end else begin
      if (capture) begin
        miss_addr_q   <= miss_addr_i;
        evict_valid_q <= evict_valid_i;
        evict_addr_q  <= evict_addr_i;
        evict_data_q  <= evict_data_i;
      end
      if (latch_vc) begin
        fill_data_q    <= vc_rdata_i;
        fill_from_vc_q <= 1'b1;
      end else if (latch_mem) begin
        fill_data_q    <= mem_rsp_data_i;
        fill_from_vc_q <= 1'b0;
      end
    end
  end

  // saturating counters; only reset clears them
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc && !(&hit_cnt_q))   hit_cnt_q  <= hit_cnt_q + CNT_WIDTH'(1);
      if (miss_inc && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ucsbece154b_victim_miss_ctrl.sv
module tb_ucsbece154b_victim_miss_ctrl;
  localparam int AW = 56;
  localparam int LW = 128;
  localparam int CW = 2;

  logic          clk_i = 0, rst_ni = 0, flush_i = 0, en_i = 1;
  logic          miss_valid_i = 0, miss_ready_o;
  logic [AW-1:0] miss_addr_i = '0;
  logic          evict_valid_i = 0;
  logic [AW-1:0] evict_addr_i = '0;
  logic [LW-1:0] evict_data_i = '0;
  logic          fill_valid_o, fill_from_vc_o;
  logic [AW-1:0] fill_addr_o, vc_raddr_o, vc_waddr_o, mem_req_addr_o;
  logic [LW-1:0] fill_data_o, vc_wdata_o;
  logic [LW-1:0] vc_rdata_i = '0;
  logic          vc_hit_i = 0, vc_we_o, mem_req_valid_o;
  logic          mem_req_ready_i = 0, mem_rsp_valid_i = 0;
  logic [LW-1:0] mem_rsp_data_i = '0;
  logic [CW-1:0] vc_hit_cnt_o, vc_miss_cnt_o;

  int nvec = 0, nerr = 0;
  int exp_hit = 0, exp_miss = 0;   // model counters (saturate at 2**CW-1)

  ucsbece154b_victim_miss_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .en_i(en_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
    .fill_valid_o(fill_valid_o), .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
    .fill_from_vc_o(fill_from_vc_o), .vc_raddr_o(vc_raddr_o), .vc_rdata_i(vc_rdata_i),
    .vc_hit_i(vc_hit_i), .vc_we_o(vc_we_o), .vc_waddr_o(vc_waddr_o), .vc_wdata_o(vc_wdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .vc_hit_cnt_o(vc_hit_cnt_o), .vc_miss_cnt_o(vc_miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [AW-1:0] rnd_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[AW-1:0];
  endfunction
  function automatic int sat(input int c);
    return (c < (1 << CW) - 1) ? c + 1 : c;
  endfunction

  task automatic next_cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic drv_flush(input bit f, input bit use_en);
    if (f) begin
      if (use_en) begin en_i = 0; flush_i = 0; end
      else        begin en_i = 1; flush_i = 1; end
    end else begin
      en_i = 1; flush_i = 0;
    end
  endtask

  // One L1 miss transaction. ph selects where a one-cycle flush lands:
  // 0 none, 1 lookup, 2 first mem-request cycle, 3 first mem-wait cycle, 4 fill.
  task automatic run_txn(input logic [AW-1:0] a, input bit ev, input logic [AW-1:0] ea,
                         input logic [LW-1:0] ed, input bit hit, input logic [LW-1:0] rd,
                         input int stall, input int rdly, input logic [LW-1:0] md,
                         input int ph, input bit use_en);
    logic [AW-1:0] la;
    bit fl, aborted, do_fill;
    la = {a[AW-1:4], 4'h0};
    aborted = 0;
    do_fill = 0;
    // handshake cycle
    miss_valid_i = 1; miss_addr_i = a;
    evict_valid_i = ev; evict_addr_i = ea; evict_data_i = ed;
    drv_flush(0, use_en);
    #1; nvec++;
    if (miss_ready_o !== 1'b1) begin
      $display("FAIL hs_ready got %b want 1", miss_ready_o); nerr++;
    end
    next_cyc();
    // scramble inputs so the design must have captured them
    miss_valid_i = 0; miss_addr_i = rnd_addr();
    evict_valid_i = 1'($urandom); evict_addr_i = rnd_addr(); evict_data_i = rnd_line();
    // lookup cycle
    fl = (ph == 1);
    drv_flush(fl, use_en); vc_hit_i = hit; vc_rdata_i = rd;
    #1; nvec++;
    if (vc_we_o !== (ev && !fl)) begin
      $display("FAIL lookup_we got %b want %b", vc_we_o, ev && !fl); nerr++;
    end
    if (ev && !fl) begin
      nvec++;
      if (vc_waddr_o !== ea || vc_wdata_o !== ed) begin
        $display("FAIL lookup_wr got %h/%h want %h/%h", vc_waddr_o, vc_wdata_o, ea, ed); nerr++;
      end
    end
    nvec++;
    if (vc_raddr_o !== a) begin
      $display("FAIL lookup_raddr got %h want %h", vc_raddr_o, a); nerr++;
    end
    nvec++;
    if ({miss_ready_o, fill_valid_o, mem_req_valid_o} !== 3'b000) begin
      $display("FAIL lookup_quiet got %b want 000", {miss_ready_o, fill_valid_o, mem_req_valid_o}); nerr++;
    end
    if (!fl) begin
      if (hit) exp_hit = sat(exp_hit); else exp_miss = sat(exp_miss);
    end
    next_cyc();
    drv_flush(0, use_en); vc_hit_i = 1'($urandom); vc_rdata_i = rnd_line();
    if (!fl) begin
      if (hit) do_fill = 1;
      else begin
        for (int i = 0; i <= stall; i++) begin
          fl = (ph == 2 && i == 0);
          drv_flush(fl, use_en);
          mem_req_ready_i = (i == stall);
          aborted |= fl;
          #1; nvec++;
          if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== la) begin
            $display("FAIL req got %b/%h want 1/%h", mem_req_valid_o, mem_req_addr_o, la); nerr++;
          end
          nvec++;
          if ({fill_valid_o, vc_we_o, miss_ready_o} !== 3'b000) begin
            $display("FAIL req_quiet got %b want 000", {fill_valid_o, vc_we_o, miss_ready_o}); nerr++;
          end
          next_cyc();
        end
        mem_req_ready_i = 0;
        for (int i = 0; i <= rdly; i++) begin
          fl = (ph == 3 && i == 0);
          drv_flush(fl, use_en);
          aborted |= fl;
          mem_rsp_valid_i = (i == rdly);
          mem_rsp_data_i  = (i == rdly) ? md : rnd_line();
          #1; nvec++;
          if ({mem_req_valid_o, fill_valid_o, miss_ready_o, vc_we_o} !== 4'b0000) begin
            $display("FAIL wait_quiet got %b want 0000",
                     {mem_req_valid_o, fill_valid_o, miss_ready_o, vc_we_o}); nerr++;
          end
          next_cyc();
        end
        mem_rsp_valid_i = 0; mem_rsp_data_i = rnd_line();
        drv_flush(0, use_en);
        do_fill = !aborted;
      end
    end
    if (do_fill) begin
      fl = (ph == 4);
      drv_flush(fl, use_en);
      #1; nvec++;
      if (fill_valid_o !== !fl || miss_ready_o !== 1'b0) begin
        $display("FAIL fill_vld got %b/rdy %b want %b/0", fill_valid_o, miss_ready_o, !fl); nerr++;
      end
      if (!fl) begin
        nvec++;
        if (fill_addr_o !== la || fill_data_o !== (hit ? rd : md) || fill_from_vc_o !== hit) begin
          $display("FAIL fill_data got %h/%h/%b want %h/%h/%b", fill_addr_o, fill_data_o,
                   fill_from_vc_o, la, hit ? rd : md, hit); nerr++;
        end
      end
      next_cyc();
      drv_flush(0, use_en);
    end
    // back in idle: no fill, ready again, counters as modelled
    #1; nvec++;
    if (miss_ready_o !== 1'b1 || fill_valid_o !== 1'b0) begin
      $display("FAIL idle got rdy %b fill %b want 1/0", miss_ready_o, fill_valid_o); nerr++;
    end
    nvec++;
    if (vc_hit_cnt_o !== CW'(exp_hit) || vc_miss_cnt_o !== CW'(exp_miss)) begin
      $display("FAIL counters got %0d/%0d want %0d/%0d", vc_hit_cnt_o, vc_miss_cnt_o,
               exp_hit, exp_miss); nerr++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 0;
    #3; nvec++;
    if ({fill_valid_o, vc_we_o, mem_req_valid_o, fill_from_vc_o} !== 4'b0 ||
        vc_hit_cnt_o !== '0 || vc_miss_cnt_o !== '0 || fill_addr_o !== '0 ||
        fill_data_o !== '0 || vc_raddr_o !== '0 || vc_waddr_o !== '0 || vc_wdata_o !== '0) begin
      $display("FAIL reset_outs got fv%b we%b rq%b hc%0d mc%0d", fill_valid_o, vc_we_o,
               mem_req_valid_o, vc_hit_cnt_o, vc_miss_cnt_o); nerr++;
    end
    next_cyc(); rst_ni = 1;
    #1; nvec++;
    if (miss_ready_o !== 1'b1) begin
      $display("FAIL reset_ready got %b want 1", miss_ready_o); nerr++;
    end
    // drive a miss into the memory-wait state, then reset mid-flight
    miss_valid_i = 1; miss_addr_i = 56'h5555; evict_valid_i = 1;
    evict_addr_i = 56'h7700; evict_data_i = rnd_line();
    next_cyc(); miss_valid_i = 0; evict_valid_i = 0; vc_hit_i = 0;
    next_cyc(); mem_req_ready_i = 1;
    next_cyc(); mem_req_ready_i = 0;
    #1; nvec++;
    if (vc_miss_cnt_o !== CW'(1)) begin
      $display("FAIL pre_reset_miss_cnt got %0d want 1", vc_miss_cnt_o); nerr++;
    end
    rst_ni = 0;
    #1; nvec++;
    if ({fill_valid_o, vc_we_o, mem_req_valid_o} !== 3'b0 || vc_miss_cnt_o !== '0 ||
        vc_hit_cnt_o !== '0 || vc_raddr_o !== '0 || vc_waddr_o !== '0) begin
      $display("FAIL async_reset got fv%b we%b rq%b mc%0d raddr %h", fill_valid_o, vc_we_o,
               mem_req_valid_o, vc_miss_cnt_o, vc_raddr_o); nerr++;
    end
    exp_hit = 0; exp_miss = 0;
    next_cyc(); rst_ni = 1;
    mem_rsp_valid_i = 1; mem_rsp_data_i = rnd_line();   // stale response
    #1; nvec++;
    if (miss_ready_o !== 1'b1) begin
      $display("FAIL post_reset_ready got %b want 1", miss_ready_o); nerr++;
    end
    next_cyc(); mem_rsp_valid_i = 0;
    #1; nvec++;
    if ({fill_valid_o, mem_req_valid_o, vc_we_o} !== 3'b0 || miss_ready_o !== 1'b1) begin
      $display("FAIL stale_rsp got fv%b rq%b we%b rdy%b", fill_valid_o, mem_req_valid_o,
               vc_we_o, miss_ready_o); nerr++;
    end
  endtask

  task automatic test_hit_swap();
    logic [LW-1:0] da, db;
    da = rnd_line(); db = rnd_line();
    run_txn(56'h1040, 1, 56'h2000, da, 1, db, 0, 0, '0, 0, 0);
  endtask

  task automatic test_vc_miss();
    run_txn(56'h3047, 0, '0, '0, 0, '0, 3, 1, rnd_line(), 0, 0);
  endtask

  task automatic test_flush_mem_wait();
    run_txn(56'h4abc, 1, 56'h9000, rnd_line(), 0, '0, 1, 2, rnd_line(), 3, 0);
    run_txn(56'h4ac0, 0, '0, '0, 0, '0, 0, 0, rnd_line(), 0, 0);
  endtask

  task automatic test_flush_lookup();
    run_txn(56'h6010, 1, 56'h8010, rnd_line(), 1, rnd_line(), 0, 0, '0, 1, 0);
    run_txn(56'h6020, 1, 56'h8020, rnd_line(), 1, rnd_line(), 0, 0, '0, 1, 1);
  endtask

  task automatic test_flush_handshake();
    miss_valid_i = 1; miss_addr_i = 56'h7000; evict_valid_i = 1;
    evict_addr_i = 56'h7100; vc_hit_i = 0; flush_i = 1;
    #1; nvec++;
    if (miss_ready_o !== 1'b0) begin
      $display("FAIL hs_flush_ready got %b want 0", miss_ready_o); nerr++;
    end
    next_cyc(); miss_valid_i = 0; evict_valid_i = 0; flush_i = 0;
    for (int i = 0; i < 2; i++) begin
      #1; nvec++;
      if ({vc_we_o, mem_req_valid_o, fill_valid_o} !== 3'b0 || miss_ready_o !== 1'b1) begin
        $display("FAIL hs_flush_idle got we%b rq%b fv%b rdy%b", vc_we_o, mem_req_valid_o,
                 fill_valid_o, miss_ready_o); nerr++;
      end
      next_cyc();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++)
      run_txn(rnd_addr(), 1'($urandom), rnd_addr(), rnd_line(), 1, rnd_line(), 0, 0, '0, 0, 0);
    nvec++;
    if (vc_hit_cnt_o !== 2'd3) begin
      $display("FAIL hit_saturate got %0d want 3", vc_hit_cnt_o); nerr++;
    end
  endtask

  task automatic test_back_to_back();
    int ph;
    for (int n = 0; n < 40; n++) begin
      ph = $urandom_range(0, 8);
      if (ph > 4) ph = 0;
      run_txn(rnd_addr(), 1'($urandom), rnd_addr(), rnd_line(), 1'($urandom), rnd_line(),
              $urandom_range(0, 3), $urandom_range(0, 3), rnd_line(), ph, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_hit_swap();
    test_vc_miss();
    test_flush_mem_wait();
    test_flush_lookup();
    test_flush_handshake();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ucsbece154b_victim_miss_ctrl.md
Name: ucsbece154b_victim_miss_ctrl

Overview:
- Miss/swap controller between a clean (read-only, instruction-side) L1 and the fully-associative victim cache.
- On an L1 miss it probes the victim cache and writes the L1's evicted line into the victim cache.
- On a victim hit it returns the line to L1 as a swap; on a victim miss it fetches the line from memory over a valid/ready request and valid response channel.
- It keeps saturating hit and miss counters.

Parameters:
ADDR_WIDTH, 56, byte-address width; OFFSET_WIDTH = $clog2(LINE_WIDTH/8)
LINE_WIDTH, 128, cache line width in bits
CNT_WIDTH, 32, width of each performance counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous active-low
flush_i  in  1  flush; aborts or suppresses the in-flight miss
en_i  in  1  enable; low behaves as flush_i
miss_valid_i  in  1  L1 miss request
miss_ready_o  out  1  controller idle and accepting
miss_addr_i  in  ADDR_WIDTH  missing address
evict_valid_i  in  1  L1 evicts a valid line with this miss
evict_addr_i  in  ADDR_WIDTH  evicted line address
evict_data_i  in  LINE_WIDTH  evicted line data
fill_valid_o  out  1  one-cycle fill pulse to L1
fill_addr_o  out  ADDR_WIDTH  line-aligned fill address
fill_data_o  out  LINE_WIDTH  fill data
fill_from_vc_o  out  1  1 = fill sourced from victim cache
vc_raddr_o  out  ADDR_WIDTH  victim cache read address
vc_rdata_i  in  LINE_WIDTH  victim cache read data
vc_hit_i  in  1  victim cache hit (combinational)
vc_we_o  out  1  victim cache write enable
vc_waddr_o  out  ADDR_WIDTH  victim cache write address
vc_wdata_o  out  LINE_WIDTH  victim cache write data
mem_req_valid_o  out  1  memory line request
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_WIDTH  line-aligned request address
mem_rsp_valid_i  in  1  memory response (one beat, no backpressure)
mem_rsp_data_i  in  LINE_WIDTH  response line
vc_hit_cnt_o  out  CNT_WIDTH  victim hits
vc_miss_cnt_o  out  CNT_WIDTH  victim misses

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE, abort flag clear.
  - All registered outputs 0, counters 0.
  - miss_ready_o is 1 once out of reset.
- Capture registers: miss_addr, evict valid/addr/data, fill data, fill source.
- vc_raddr_o = captured miss address at all times.
- vc_waddr_o and vc_wdata_o = captured evict address and data.
- FSM:
  - IDLE:
    - miss_ready_o = en_i & ~flush_i.
    - On miss_valid_i & miss_ready_o: capture miss and evict inputs → LOOKUP.
  - LOOKUP (exactly 1 cycle):
    - vc_we_o = captured evict_valid (always written here, hit or miss).
    - If vc_hit_i: latch vc_rdata_i, fill_from_vc=1, increment hit counter → FILL.
    - Else: increment miss counter → MEM_REQ.
  - MEM_REQ:
    - mem_req_valid_o = 1, mem_req_addr_o = miss_addr with low OFFSET_WIDTH bits zeroed.
    - Valid and address held stable until mem_req_ready_i → MEM_WAIT (same-cycle ready allowed).
  - MEM_WAIT:
    - On mem_rsp_valid_i: latch data, fill_from_vc=0 → FILL.
    - mem_rsp_valid_i outside MEM_WAIT is ignored.
  - FILL:
    - fill_valid_o = 1 for exactly one cycle, fill_addr_o line-aligned → IDLE.
    - miss_ready_o is 0 in FILL; the next handshake is no earlier than the cycle after FILL.
- Latency from handshake cycle T:
  - Victim hit: fill at T+2.
  - Victim miss: request valid at T+2; fill in the cycle after the response.
- Counters saturate at all-ones. They are cleared only by reset, not by flush.
- Flush/disable (flush_i | ~en_i):
  - In IDLE, LOOKUP or FILL: → IDLE next cycle.
    - fill_valid_o and vc_we_o forced 0 that cycle.
    - No counter increment that cycle.
  - In MEM_REQ or MEM_WAIT: set abort flag.
    - The request must still complete its handshake, and the response is still drained.
    - Then → IDLE with no FILL pulse.
  - miss_ready_o stays 0 until back in IDLE.
- Flush coincident with a handshake in IDLE: the handshake is not accepted (ready is 0).
- A duplicate tag may exist in the victim cache after a swap. This is permitted because L1 lines are clean.
- Async reset mid-operation: immediate return to IDLE; an outstanding memory response arriving later is ignored.

Test Plan:
- Reset: rst_ni=0 mid-MEM_WAIT → all outputs 0 and state IDLE immediately; counters 0; miss_ready_o=1 after release.
- Victim hit swap:
  - Stimulus: miss 0x1040 with evict 0x2000/data A; vc_hit_i=1, vc_rdata_i=B.
  - Response: vc_we_o=1 at T+1 with waddr 0x2000/wdata A; fill at T+2 with addr 0x1040, data B, fill_from_vc_o=1; hit count 1.
- Victim miss:
  - Stimulus: miss 0x3047, no evict; vc_hit_i=0; mem_req_ready_i low 3 cycles.
  - Response: request held with addr 0x3040 across the stall; response C 2 cycles after accept; fill C with fill_from_vc_o=0 the next cycle; vc_we_o never 1; miss count 1.
- Flush in MEM_WAIT → response consumed, no fill_valid_o, back to IDLE, next miss accepted normally.
- Flush during LOOKUP with vc_hit_i=1 → no vc_we_o, no fill, no counter increment.
- Counter saturation with CNT_WIDTH=2 → five victim hits leave vc_hit_cnt_o=3.
